axil_slave_regs: RTL and testbench

// - AXI4-Lite subordinate (responder) holding NUM_REGS x 32-bit read/write registers.
// - Responds to the AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST traffic issued by the

---
 rtl/axil_slave_regs_pkg.sv | 34 +++
 rtl/axil_reg_bank.sv | 66 ++++++
 rtl/axil_slave_regs.sv | 247 ++++++++++++++++++++++++
 tb/tb_axil_slave_regs.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_slave_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_slave_regs_pkg
// Description : Shared types and constants for the AXI4-Lite register slave.
//               - resp_t     : AXI response encodings
//               - wr_state_t : write-channel FSM states
//               - rd_state_t : read-channel FSM states
//               - ADDR_LSB   : first byte-address bit used as register index
// Revision    : 1.0 - initial release
// ============================================================================
package axil_slave_regs_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Registers are 32-bit words, so byte-address bits [1:0] never select one.
    localparam int ADDR_LSB = 2;

endpackage : axil_slave_regs_pkg
`default_nettype wire

// File: rtl/axil_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : axil_reg_bank
// Description : NUM_REGS x DATA_WIDTH register storage.
//               One byte-strobed synchronous write port, one combinational
//               read port. Indices >= NUM_REGS read as zero and are never
//               written.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset, clears all words
//               i_wr_en    - write enable
//               i_wr_idx   - word index to write
//               i_wr_data  - write data
//               i_wr_strb  - per-byte write enables
//               i_rd_idx   - word index to read
//               o_rd_data  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_bank #(
    parameter int NUM_REGS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [IDX_WIDTH-1:0]    i_wr_idx,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
    input  logic [IDX_WIDTH-1:0]    i_rd_idx,
    output logic [DATA_WIDTH-1:0]   o_rd_data
);

    localparam int c_num_bytes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_wr_idx == IDX_WIDTH'(i)) begin
                    for (int b = 0; b < c_num_bytes; b++) begin
                        if (i_wr_strb[b]) begin
                            r_mem[i][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Unmatched (out-of-range) indices fall through to zero.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_idx == IDX_WIDTH'(i)) begin
                o_rd_data = r_mem[i];
            end
        end
    end

endmodule : axil_reg_bank
`default_nettype wire

// File: rtl/axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : axil_slave_regs
// Description : AXI4-Lite subordinate exposing NUM_REGS x 32-bit read/write
//               registers. Independent write and read channels, one
//               outstanding transaction each. AW and W are captured in
//               separate skid registers and may arrive in any order.
// Config      : AXIL_SLAVE_REGS_SLVERR_EN
//                 defined   - out-of-range accesses answer SLVERR, writes are
//                             dropped, reads return zero.
//                 undefined - index taken modulo NUM_REGS, always OKAY.
// Ports       : ACLK, ARESETN (async active-low)
//               AW channel : S_AXI_AWADDR/AWPROT/AWVALID -> S_AXI_AWREADY
//               W  channel : S_AXI_WDATA/WSTRB/WVALID    -> S_AXI_WREADY
//               B  channel : S_AXI_BRESP/BVALID          <- S_AXI_BREADY
//               AR channel : S_AXI_ARADDR/ARPROT/ARVALID -> S_AXI_ARREADY
//               R  channel : S_AXI_RDATA/RRESP/RVALID    <- S_AXI_RREADY
// Revision    : 1.0 - initial release
// ============================================================================
module axil_slave_regs
    import axil_slave_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int c_idx_width  = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int c_strb_width = C_S_AXI_DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Holds every READY low through reset and for the first edge after it.
    logic                           r_ready_en;

    wr_state_t                      r_wr_state;
    logic                           r_aw_held;
    logic [c_idx_width-1:0]         r_aw_idx;
    logic                           r_w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0]  r_w_data;
    logic [c_strb_width-1:0]        r_w_strb;
    logic                           r_bvalid;
    resp_t                          r_bresp;

    rd_state_t                      r_rd_state;
    logic                           r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]  r_rdata;
    resp_t                          r_rresp;

    // ------------------------------------------------------------------
    // Handshakes and write-side operand selection
    // ------------------------------------------------------------------
    logic                           w_aw_hs;
    logic                           w_w_hs;
    logic                           w_ar_hs;
    logic [c_idx_width-1:0]         w_aw_idx_in;
    logic [c_idx_width-1:0]         w_ar_idx_in;
    logic [c_idx_width-1:0]         w_wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]  w_wr_data;
    logic [c_strb_width-1:0]        w_wr_strb;
    logic                           w_wr_commit;

    assign S_AXI_AWREADY = r_ready_en && (r_wr_state == W_IDLE) && !r_aw_held;
    assign S_AXI_WREADY  = r_ready_en && (r_wr_state == W_IDLE) && !r_w_held;
    assign S_AXI_ARREADY = r_ready_en && (r_rd_state == R_IDLE);

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign w_aw_idx_in = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign w_ar_idx_in = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

    // A channel either already sits in its skid register or is handshaking
    // this edge; the held copy takes priority since READY is low while held.
    assign w_wr_idx  = r_aw_held ? r_aw_idx : w_aw_idx_in;
    assign w_wr_data = r_w_held  ? r_w_data : S_AXI_WDATA;
    assign w_wr_strb = r_w_held  ? r_w_strb : S_AXI_WSTRB;

    assign w_wr_commit = (r_wr_state == W_IDLE)
                      && (r_aw_held || w_aw_hs)
                      && (r_w_held  || w_w_hs);

    // ------------------------------------------------------------------
    // Address decode: range check or aliasing
    // ------------------------------------------------------------------
    logic                           w_bank_wr_en;
    logic [c_idx_width-1:0]         w_bank_wr_idx;
    logic [c_idx_width-1:0]         w_bank_rd_idx;
    resp_t                          w_wr_resp;
    resp_t                          w_rd_resp;
    logic [C_S_AXI_DATA_WIDTH-1:0]  w_bank_rd_data;

`ifdef AXIL_SLAVE_REGS_SLVERR_EN
    logic w_wr_in_range;
    logic w_rd_in_range;

    assign w_wr_in_range = (int'(w_wr_idx) < NUM_REGS);
    assign w_rd_in_range = (int'(w_ar_idx_in) < NUM_REGS);

    assign w_bank_wr_en  = w_wr_commit && w_wr_in_range;
    assign w_bank_wr_idx = w_wr_idx;
    assign w_bank_rd_idx = w_ar_idx_in;
    assign w_wr_resp     = w_wr_in_range ? OKAY : SLVERR;
    assign w_rd_resp     = w_rd_in_range ? OKAY : SLVERR;
`else
    assign w_bank_wr_en  = w_wr_commit;
    assign w_bank_wr_idx = c_idx_width'(int'(w_wr_idx) % NUM_REGS);
    assign w_bank_rd_idx = c_idx_width'(int'(w_ar_idx_in) % NUM_REGS);
    assign w_wr_resp     = OKAY;
    assign w_rd_resp     = OKAY;
`endif

    // ------------------------------------------------------------------
    // Register storage. Out-of-range read indices return zero from the bank.
    // ------------------------------------------------------------------
    axil_reg_bank #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .IDX_WIDTH  (c_idx_width)
    ) u_reg_bank (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .i_wr_en    (w_bank_wr_en),
        .i_wr_idx   (w_bank_wr_idx),
        .i_wr_data  (w_wr_data),
        .i_wr_strb  (w_wr_strb),
        .i_rd_idx   (w_bank_rd_idx),
        .o_rd_data  (w_bank_rd_data)
    );

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_state <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_held   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_wr_commit) begin
                        r_wr_state <= W_RESP;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_wr_resp;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_idx  <= w_aw_idx_in;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_w_data <= S_AXI_WDATA;
                            r_w_strb <= S_AXI_WSTRB;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_wr_state <= W_IDLE;
                        r_bvalid   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // The read data is captured from the bank before any same-edge write
    // lands, so a colliding read returns the old contents.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rd_state <= R_IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_state <= R_RESP;
                        r_rvalid   <= 1'b1;
                        r_rdata    <= w_bank_rd_data;
                        r_rresp    <= w_rd_resp;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        r_rd_state <= R_IDLE;
                        r_rvalid   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;

    // Protection bits and the byte offset carry no meaning for word registers.
    logic w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule : axil_slave_regs
`default_nettype wire

// File: tb/tb_axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_slave_regs
// Description : Directed self-checking bench for axil_slave_regs. Two
//               instances share all inputs: u_dut_a with NUM_REGS=4 and
//               u_dut_b with NUM_REGS=3 (for the out-of-range accesses).
// Config      : AXIL_SLAVE_REGS_SLVERR_EN selects the expected
//               out-of-range behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_slave_regs;

`ifdef AXIL_SLAVE_REGS_SLVERR_EN
    localparam bit c_slverr = 1'b1;
`else
    localparam bit c_slverr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        rready;
    logic [2:0]  prot = 3'b000;

    logic a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
    logic [1:0]  a_bresp, a_rresp;
    logic [31:0] a_rdata;
    logic b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
    logic [1:0]  b_bresp, b_rresp;
    logic [31:0] b_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .NUM_REGS           (4)
    ) u_dut_a (
        .ACLK (clk), .ARESETN (aresetn),
        .S_AXI_AWADDR (awaddr), .S_AXI_AWPROT (prot), .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (a_awready),
        .S_AXI_WDATA (wdata), .S_AXI_WSTRB (wstrb), .S_AXI_WVALID (wvalid), .S_AXI_WREADY (a_wready),
        .S_AXI_BRESP (a_bresp), .S_AXI_BVALID (a_bvalid), .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr), .S_AXI_ARPROT (prot), .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (a_arready),
        .S_AXI_RDATA (a_rdata), .S_AXI_RRESP (a_rresp), .S_AXI_RVALID (a_rvalid), .S_AXI_RREADY (rready)
    );

    axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .NUM_REGS           (3)
    ) u_dut_b (
        .ACLK (clk), .ARESETN (aresetn),
        .S_AXI_AWADDR (awaddr), .S_AXI_AWPROT (prot), .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (b_awready),
        .S_AXI_WDATA (wdata), .S_AXI_WSTRB (wstrb), .S_AXI_WVALID (wvalid), .S_AXI_WREADY (b_wready),
        .S_AXI_BRESP (b_bresp), .S_AXI_BVALID (b_bvalid), .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr), .S_AXI_ARPROT (prot), .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (b_arready),
        .S_AXI_RDATA (b_rdata), .S_AXI_RRESP (b_rresp), .S_AXI_RVALID (b_rvalid), .S_AXI_RREADY (rready)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers: called at a negedge, return at a negedge with all VALIDs low.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] ra, output logic [1:0] rb);
        bit aw_done = 0;
        bit w_done  = 0;
        int n = 0;
        ra = 2'bxx;
        rb = 2'bxx;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            if (awvalid && a_awready) aw_done = 1;
            if (wvalid && a_wready)   w_done  = 1;
            @(negedge clk);
            n++;
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!a_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (a_bvalid) begin
            ra = a_bresp;
            rb = b_bresp;
            @(negedge clk);
        end else begin
            tests++; fails++;
            $display("FAIL write_timeout addr=%h: got bvalid=%b, want 1", addr, a_bvalid);
        end
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr,
                            output logic [31:0] da, output logic [1:0] ra,
                            output logic [31:0] db, output logic [1:0] rb);
        int n = 0;
        da = 'x; ra = 'x; db = 'x; rb = 'x;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!a_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!a_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (a_rvalid) begin
            da = a_rdata; ra = a_rresp; db = b_rdata; rb = b_rresp;
            @(negedge clk);
        end else begin
            tests++; fails++;
            $display("FAIL read_timeout addr=%h: got rvalid=%b, want 1", addr, a_rvalid);
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_awready, a_wready, a_bresp, a_bvalid, a_arready, a_rdata, a_rresp, a_rvalid} !== 41'd0) begin
            fails++;
            $display("FAIL reset_outputs_a: got aw=%b w=%b ar=%b bv=%b rv=%b, want all 0",
                     a_awready, a_wready, a_arready, a_bvalid, a_rvalid);
        end
        tests++;
        if ({b_awready, b_wready, b_bresp, b_bvalid, b_arready, b_rdata, b_rresp, b_rvalid} !== 41'd0) begin
            fails++;
            $display("FAIL reset_outputs_b: got aw=%b w=%b ar=%b, want all 0", b_awready, b_wready, b_arready);
        end
        aresetn = 1'b1;
        #1;
        tests++;
        if ({a_awready, a_wready, a_arready} !== 3'b000) begin
            fails++;
            $display("FAIL ready_at_release: got %b, want 000", {a_awready, a_wready, a_arready});
        end
        @(negedge clk);
        tests++;
        if ({a_awready, a_wready, a_arready, b_awready, b_wready, b_arready} !== 6'b111111) begin
            fails++;
            $display("FAIL ready_after_release: got %b, want 111111",
                     {a_awready, a_wready, a_arready, b_awready, b_wready, b_arready});
        end
    endtask

    task automatic test_sequential();
        logic [1:0] ra, rb;
        logic [31:0] da, db;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, ra, rb);
            tests++;
            if (ra !== 2'b00) begin
                fails++;
                $display("FAIL seq_bresp[%0d]: got %b, want 00", i, ra);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), da, ra, db, rb);
            tests++;
            if (da !== 32'(i + 1) || ra !== 2'b00) begin
                fails++;
                $display("FAIL seq_read[%0d]: got %h/%b, want %h/00", i, da, ra, 32'(i + 1));
            end
        end
    endtask

    task automatic test_wstrb();
        logic [1:0] ra, rb;
        logic [31:0] da, db;
        axi_write(4'h4, 32'h11223344, 4'hF, ra, rb);
        axi_write(4'h4, 32'hAABBCCDD, 4'b0101, ra, rb);
        axi_read(4'h4, da, ra, db, rb);
        tests++;
        if (da !== 32'h11BB33DD) begin
            fails++;
            $display("FAIL wstrb_merge: got %h, want 11bb33dd", da);
        end
    endtask

    task automatic test_aw_w_order(input bit w_first, input logic [31:0] data);
        logic [1:0] ra, rb;
        logic [31:0] da, db;
        awaddr = 4'h8; wdata = data; wstrb = 4'hF; bready = 1'b0;
        if (w_first) wvalid = 1'b1; else awvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; awvalid = 1'b0;
        tests++;
        if ((w_first ? a_wready : a_awready) !== 1'b0) begin
            fails++;
            $display("FAIL order_lead_held w_first=%0d: got ready=1, want 0", w_first);
        end
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (a_bvalid !== 1'b0) begin
                fails++;
                $display("FAIL order_early_bvalid w_first=%0d: got %b, want 0", w_first, a_bvalid);
            end
        end
        if (w_first) awvalid = 1'b1; else wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        tests++;
        if ({a_bvalid, a_bresp, a_awready, a_wready} !== 5'b10000) begin
            fails++;
            $display("FAIL order_bvalid w_first=%0d: got bv=%b bresp=%b awr=%b wr=%b, want 1 00 0 0",
                     w_first, a_bvalid, a_bresp, a_awready, a_wready);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        tests++;
        if (a_bvalid !== 1'b0) begin
            fails++;
            $display("FAIL order_single_b w_first=%0d: got bvalid=%b, want 0", w_first, a_bvalid);
        end
        axi_read(4'h8, da, ra, db, rb);
        tests++;
        if (da !== data) begin
            fails++;
            $display("FAIL order_readback w_first=%0d: got %h, want %h", w_first, da, data);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] ra, rb;
        logic [31:0] da, db;
        awaddr = 4'hC; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h0; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tests++;
            if ({a_bvalid, a_bresp, a_rvalid, a_rdata, a_rresp, a_awready, a_wready, a_arready}
                    !== {1'b1, 2'b00, 1'b1, 32'h1, 2'b00, 3'b000}) begin
                fails++;
                $display("FAIL backpressure_stable[%0d]: got bv=%b br=%b rv=%b rd=%h rr=%b rdy=%b, want 1 00 1 00000001 00 000",
                         c, a_bvalid, a_bresp, a_rvalid, a_rdata, a_rresp, {a_awready, a_wready, a_arready});
            end
            @(negedge clk);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        tests++;
        if ({a_bvalid, a_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL backpressure_release: got bv=%b rv=%b, want 0 0", a_bvalid, a_rvalid);
        end
        axi_read(4'hC, da, ra, db, rb);
        tests++;
        if (da !== 32'h12345678) begin
            fails++;
            $display("FAIL backpressure_readback: got %h, want 12345678", da);
        end
    endtask

    task automatic test_collision();
        logic [1:0] ra, rb;
        logic [31:0] da, db;
        axi_write(4'h0, 32'h5, 4'hF, ra, rb);
        awaddr = 4'h0; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h0; arvalid = 1'b1; bready = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tests++;
        if ({a_rvalid, a_rdata, a_bvalid} !== {1'b1, 32'h5, 1'b1}) begin
            fails++;
            $display("FAIL collision_old_data: got rv=%b rd=%h bv=%b, want 1 00000005 1", a_rvalid, a_rdata, a_bvalid);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        axi_read(4'h0, da, ra, db, rb);
        tests++;
        if (da !== 32'h9) begin
            fails++;
            $display("FAIL collision_new_data: got %h, want 00000009", da);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] ra, rb;
        logic [31:0] da, db;
        logic [1:0]  exp_resp;
        logic [31:0] exp_oor_data;
        logic [31:0] exp_reg0;
        exp_resp     = c_slverr ? 2'b10 : 2'b00;
        exp_oor_data = c_slverr ? 32'h0 : 32'h55;
        exp_reg0     = c_slverr ? 32'h77 : 32'h55;
        axi_write(4'h0, 32'h77, 4'hF, ra, rb);
        axi_write(4'hC, 32'h55, 4'hF, ra, rb);
        tests++;
        if (rb !== exp_resp || ra !== 2'b00) begin
            fails++;
            $display("FAIL oor_bresp: got b=%b a=%b, want b=%b a=00", rb, ra, exp_resp);
        end
        axi_read(4'hC, da, ra, db, rb);
        tests++;
        if (db !== exp_oor_data || rb !== exp_resp) begin
            fails++;
            $display("FAIL oor_read: got %h/%b, want %h/%b", db, rb, exp_oor_data, exp_resp);
        end
        tests++;
        if (da !== 32'h55 || ra !== 2'b00) begin
            fails++;
            $display("FAIL oor_inrange_a: got %h/%b, want 00000055/00", da, ra);
        end
        axi_read(4'h0, da, ra, db, rb);
        tests++;
        if (db !== exp_reg0 || rb !== 2'b00) begin
            fails++;
            $display("FAIL oor_reg0: got %h/%b, want %h/00", db, rb, exp_reg0);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] ra, rb;
        logic [31:0] da, db;
        awaddr = 4'h4; wdata = 32'hFFFF0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        tests++;
        if (a_bvalid !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_bvalid: got %b, want 1", a_bvalid);
        end
        #2 aresetn = 1'b0;
        #1;
        tests++;
        if ({a_awready, a_wready, a_bresp, a_bvalid, a_arready, a_rdata, a_rresp, a_rvalid,
             b_awready, b_wready, b_bresp, b_bvalid, b_arready, b_rdata, b_rresp, b_rvalid} !== 82'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got a_bv=%b b_bv=%b a_rd=%h, want all 0", a_bvalid, b_bvalid, a_rdata);
        end
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        tests++;
        if (a_bvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_no_b: got bvalid=%b, want 0", a_bvalid);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), da, ra, db, rb);
            tests++;
            if (da !== 32'h0 || (i < 3 && db !== 32'h0)) begin
                fails++;
                $display("FAIL reset_mid_reg[%0d]: got a=%h b=%h, want 0", i, da, db);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wstrb();
        test_aw_w_order(1'b1, 32'hDEADBEEF);
        test_aw_w_order(1'b0, 32'hCAFEF00D);
        test_backpressure();
        test_collision();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_axil_slave_regs
`default_nettype wire
